// File: rtl/tsi_cond_pkg.sv
// ============================================================================
// Package   : tsi_cond_pkg
// Purpose   : Shared constants and helpers for the board I/O conditioning block:
//             synchroniser depth limits, default debounce window, and the
//             debounce-counter width function.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package tsi_cond_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // 10 ms settling window at a 100 MHz system clock.
  localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;

  // The counter only ever holds 0..cyc-1. A window of 1 needs no counter at
  // all, but a zero-width vector is illegal, so the width floors at 1 bit.
  function automatic int cnt_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tsi_cond_if.sv
// ============================================================================
// Interface : tsi_cond_if
// Purpose   : Bundles the conditioned board I/O of tsi_cond.
//   in_i     raw switch/button inputs        level_o  debounced level
//   rise_o   0->1 pulse on level_o           fall_o   1->0 pulse on level_o
//   rx_i     raw UART receive line           rx_o     synchronised RX
//   out_i    internal LED drive              out_o    registered pad drive
// Modports  : master = fabric/bench side, slave = tsi_cond side.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tsi_cond_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 16
);

  logic [N_IN-1:0]  in_i;
  logic [N_IN-1:0]  level_o;
  logic [N_IN-1:0]  rise_o;
  logic [N_IN-1:0]  fall_o;
  logic             rx_i;
  logic             rx_o;
  logic [N_OUT-1:0] out_i;
  logic [N_OUT-1:0] out_o;

  modport master (
    output in_i, rx_i, out_i,
    input  level_o, rise_o, fall_o, rx_o, out_o
  );

  modport slave (
    input  in_i, rx_i, out_i,
    output level_o, rise_o, fall_o, rx_o, out_o
  );

endinterface

`default_nettype wire

// File: rtl/tsi_cond_debounce_cell.sv
// ============================================================================
// Module    : tsi_cond_debounce_cell
// Purpose   : One input channel: SYNC_STAGES-deep synchroniser, stability
//             counter, and registered rise/fall pulses aligned with the
//             level change.
// Ports     : clk, rst_n (async active-low), in_i (raw bit),
//             level_o (debounced level), rise_o / fall_o (1-cycle pulses)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tsi_cond_debounce_cell
  import tsi_cond_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter logic RST_VAL      = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic in_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      fall_o
);

  localparam int               CNT_W  = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Any sample equal to the current level restarts the window, so a glitch
  // shorter than DEBOUNCE_CYC never reaches the level. The counter stops at
  // C_LAST because reaching it always accepts the new level and clears it.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != lvl_q) begin
      if (cnt_q == C_LAST) begin
        lvl_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/tsi_cond.sv
// ============================================================================
// Module    : tsi_cond
// Purpose   : Board I/O boundary conditioning. Synchronises and debounces
//             switch/button inputs, synchronises the UART RX line, registers
//             LED outputs with per-bit polarity, and produces a reset for
//             downstream logic (async assert, sync deassert).
// Ports     : clk      system clock
//             rst_n    asynchronous active-low board reset
//             rst_n_o  conditioned reset for downstream logic
//             bus      tsi_cond_if.slave (inputs, levels, edges, RX, LEDs)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tsi_cond
  import tsi_cond_pkg::*;
#(
  parameter int               N_IN         = 8,
  parameter int               N_OUT        = 16,
  parameter int               SYNC_STAGES  = SYNC_STAGES_MIN,
  parameter int               DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter logic [N_IN-1:0]  IN_RST_VAL   = '0,
  parameter logic [N_OUT-1:0] OUT_RST_VAL  = '0,
  parameter logic [N_OUT-1:0] OUT_INVERT   = '0
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  output logic        rst_n_o,
  tsi_cond_if.slave   bus
);

  logic [1:0]             rst_sync_q;
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic [N_OUT-1:0]       out_q;
  logic [N_IN-1:0]        level_w;
  logic [N_IN-1:0]        rise_w;
  logic [N_IN-1:0]        fall_w;

  // Downstream reset: clears with the board reset, releases on the second
  // clock edge after it goes away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_o = rst_sync_q[1];

  // RX idles high, so the chain resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync_q <= {SYNC_STAGES{1'b1}};
    else        rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], bus.rx_i};
  end
  assign bus.rx_o = rx_sync_q[SYNC_STAGES-1];

  // Polarity is applied before the register so the pad sees a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= OUT_RST_VAL ^ OUT_INVERT;
    else        out_q <= bus.out_i ^ OUT_INVERT;
  end
  assign bus.out_o = out_q;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
    tsi_cond_debounce_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RST_VAL      (IN_RST_VAL[gi])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_i    (bus.in_i[gi]),
      .level_o (level_w[gi]),
      .rise_o  (rise_w[gi]),
      .fall_o  (fall_w[gi])
    );
  end

  assign bus.level_o = level_w;
  assign bus.rise_o  = rise_w;
  assign bus.fall_o  = fall_w;

endmodule

`default_nettype wire
